// File: rtl/conv11_input_feeder.sv
// Producer for the conv1x1 input buffer: walks a feature map in RAM (channel innermost) and pushes one word per handshake.
// Optional stall-cycle counter output is enabled by defining CONV11_FEEDER_STALL_CNT_EN.
module conv11_input_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int IMG_W      = 4,
  parameter int IMG_H      = 4,
  parameter int IN_CH      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  inputbuf_load,
  output logic                  input_valid,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  last_ch,
  output logic                  last_word,
  output logic                  busy,
  output logic                  done
`ifdef CONV11_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  // state   | meaning
  // IDLE    | waiting for start
  // FETCH   | RAM read issued for word widx
  // CAPTURE | RAM data lands in the stage register
  // PUSH    | waiting for an empty buffer, then push; prefetch next word in the push cycle
  // DONE    | one-cycle completion pulse

  localparam int TOTAL  = IMG_W * IMG_H * IN_CH;
  localparam int WIDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CH_W   = (IN_CH > 1) ? $clog2(IN_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PUSH    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [WIDX_W-1:0]     r_widx;
  logic [CH_W-1:0]       r_ch;
  logic [DATA_WIDTH-1:0] r_stage;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic                  r_pushed_q;

  logic                  w_start_ok;
  logic                  w_can_push;
  logic                  w_push;
  logic                  w_is_last_word;
  logic                  w_is_last_ch;
  logic                  w_prefetch;
  logic [WIDX_W-1:0]     w_widx_nxt;

  assign w_start_ok     = (r_state == S_IDLE) && start;
  // A push needs an empty buffer and no push in the previous cycle.
  assign w_can_push     = !inputbuf_load && !r_pushed_q;
  assign w_push         = (r_state == S_PUSH) && w_can_push;
  assign w_is_last_word = (r_widx == WIDX_W'(TOTAL - 1));
  assign w_is_last_ch   = (r_ch == CH_W'(IN_CH - 1));
  assign w_prefetch     = w_push && !w_is_last_word;
  assign w_widx_nxt     = r_widx + WIDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_FETCH;
      S_FETCH:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_PUSH;
      S_PUSH: begin
        if (w_push) w_state_nxt = w_is_last_word ? S_DONE : S_CAPTURE;
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en   = (r_state == S_FETCH) || w_prefetch;
    mem_addr    = '0;
    if (r_state == S_FETCH) begin
      mem_addr = r_base + ADDR_WIDTH'(r_widx);
    end else if (w_prefetch) begin
      mem_addr = r_base + ADDR_WIDTH'(w_widx_nxt);
    end
    input_valid = w_push;
    data_in     = w_push ? r_stage : r_data_hold;
    last_ch     = w_push && w_is_last_ch;
    last_word   = w_push && w_is_last_word;
    busy        = (r_state == S_FETCH) || (r_state == S_CAPTURE) || (r_state == S_PUSH);
    done        = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_widx      <= '0;
      r_ch        <= '0;
      r_stage     <= '0;
      r_data_hold <= '0;
      r_pushed_q  <= 1'b0;
    end else begin
      r_pushed_q <= w_push;
      if (w_start_ok) begin
        r_base <= base_addr;
        r_widx <= '0;
        r_ch   <= '0;
      end
      if (r_state == S_CAPTURE) begin
        r_stage <= mem_rd_data;
      end
      if (w_push) begin
        // data_in must keep showing the last pushed word, not the prefetched stage
        r_data_hold <= r_stage;
      end
      if (w_prefetch) begin
        r_widx <= w_widx_nxt;
        r_ch   <= w_is_last_ch ? '0 : r_ch + CH_W'(1);
      end
    end
  end

`ifdef CONV11_FEEDER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_PUSH) && !w_can_push && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv11_input_feeder.sv
// Randomized self-checking bench for conv11_input_feeder with a RAM model, a buffer/consumer model and a pass-level reference.
// Define CONV11_FEEDER_STALL_CNT_EN to also check the stall counter.
module tb_conv11_input_feeder;
  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int IW    = 2;
  localparam int IH    = 2;
  localparam int IC    = 3;
  localparam int TOTAL = IW * IH * IC;
  localparam int NREC  = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          inputbuf_load;
  logic          input_valid;
  logic [DW-1:0] data_in;
  logic          last_ch;
  logic          last_word;
  logic          busy;
  logic          done;
`ifdef CONV11_FEEDER_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  conv11_input_feeder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(IW), .IMG_H(IH), .IN_CH(IC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .inputbuf_load(inputbuf_load), .input_valid(input_valid), .data_in(data_in),
    .last_ch(last_ch), .last_word(last_word), .busy(busy), .done(done)
`ifdef CONV11_FEEDER_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // synchronous-read feature-map RAM
  logic [DW-1:0] ram [1 << AW];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  // single-entry buffer with a consumer that waits dly[k] extra cycles before reading word k
  int dly [TOTAL];
  int cwait;
  int cidx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inputbuf_load <= 1'b0;
      cwait         <= 0;
      cidx          <= 0;
    end else if (input_valid) begin
      inputbuf_load <= 1'b1;
      cwait         <= dly[cidx];
      cidx          <= (cidx == TOTAL - 1) ? 0 : cidx + 1;
    end else if (inputbuf_load) begin
      if (cwait == 0) inputbuf_load <= 1'b0;
      else            cwait <= cwait - 1;
    end
  end

  // observation log, sampled mid-cycle
  int          cyc = 0;
  int          npush = 0, nrd = 0, ndone = 0, done_cyc = 0;
  int          hold_viol = 0, rule_viol = 0, done_busy_viol = 0;
  logic [DW-1:0] last_data = '0;
  bit          prev_iv = 1'b0;
  logic [DW-1:0] pv_data [NREC];
  bit          pv_lc [NREC];
  bit          pv_lw [NREC];
  int          pv_cyc [NREC];
  int          pv_rd [NREC];
  logic [AW-1:0] rd_addr [NREC];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_data = '0;
      prev_iv   = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (nrd < NREC) rd_addr[nrd] = mem_addr;
        nrd++;
      end
      if (input_valid) begin
        if (inputbuf_load || prev_iv) rule_viol++;
        if (npush < NREC) begin
          pv_data[npush] = data_in;
          pv_lc[npush]   = last_ch;
          pv_lw[npush]   = last_word;
          pv_cyc[npush]  = cyc;
          pv_rd[npush]   = nrd;
        end
        npush++;
        last_data = data_in;
      end else if (data_in !== last_data || last_ch !== 1'b0 || last_word !== 1'b0) begin
        hold_viol++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        if (busy) done_busy_viol++;
      end
      prev_iv = input_valid;
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_input_valid"}, 32'(input_valid), 0);
    chk({tag, "_mem_rd_en"},   32'(mem_rd_en), 0);
    chk({tag, "_mem_addr"},    32'(mem_addr), 0);
    chk({tag, "_data_in"},     32'(data_in), 0);
    chk({tag, "_last_ch"},     32'(last_ch), 0);
    chk({tag, "_last_word"},   32'(last_word), 0);
    chk({tag, "_busy"},        32'(busy), 0);
    chk({tag, "_done"},        32'(done), 0);
  endtask

  task automatic fill_seq(input logic [AW-1:0] base);
    for (int k = 0; k < TOTAL; k++) ram[AW'(base + AW'(k))] = DW'(k + 1);
  endtask

  task automatic fill_rand(input logic [AW-1:0] base);
    for (int k = 0; k < TOTAL; k++) ram[AW'(base + AW'(k))] = DW'($urandom);
  endtask

  task automatic set_dly(input int maxd);
    for (int k = 0; k < TOTAL; k++) dly[k] = (maxd == 0) ? 0 : int'($urandom_range(maxd, 0));
  endtask

  // mode bit0: extra start 5 cycles into the pass; bit1: start in the done cycle
  task automatic run_pass(input logic [AW-1:0] base, input int mode, input string tag);
    int p0, r0, d0, hv0, rv0, dbv0, sc, n, pend, sum;
    logic [9:0] exp_w;
    p0 = npush; r0 = nrd; d0 = ndone; hv0 = hold_viol; rv0 = rule_viol; dbv0 = done_busy_viol;
    sum = 0;
    for (int k = 0; k < TOTAL - 1; k++) sum += dly[k];
    @(negedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    sc        = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (ndone == d0 && n < 1000) begin
      if (cyc == sc + 2) chk({tag, "_busy_mid"}, 32'(busy), 1);
      if ((mode & 1) != 0 && cyc == sc + 5) begin
        start     = 1'b1;
        base_addr = ~base;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_timeout"}, 32'(ndone == d0), 0);
    pend = npush;
    if ((mode & 2) != 0) begin
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk({tag, "_start_at_done_busy"}, 32'(busy), 0);
      chk({tag, "_start_at_done_pushes"}, 32'(npush - pend), 0);
    end
    repeat (8) @(negedge clk);
    #1;
    chk({tag, "_npush"}, 32'(npush - p0), TOTAL);
    chk({tag, "_ndone"}, 32'(ndone - d0), 1);
    chk({tag, "_nreads"}, 32'(nrd - r0), TOTAL);
    chk({tag, "_latency"}, 32'(pv_cyc[p0] - sc), 3);
    chk({tag, "_reads_by_push0"}, 32'(pv_rd[p0] - r0), (TOTAL > 1) ? 2 : 1);
    for (int k = 0; k < TOTAL; k++) begin
      exp_w = {ram[AW'(base + AW'(k))], (k % IC) == IC - 1, k == TOTAL - 1};
      chk({tag, "_word"}, 32'({pv_data[p0 + k], pv_lc[p0 + k], pv_lw[p0 + k]}), 32'(exp_w));
      chk({tag, "_rd_addr"}, 32'(rd_addr[r0 + k]), 32'(AW'(base + AW'(k))));
      if (k > 0) begin
        chk({tag, "_push_gap"}, 32'(pv_cyc[p0 + k] - pv_cyc[p0 + k - 1]), 32'(2 + dly[k - 1]));
        chk({tag, "_reads_between"}, 32'(pv_rd[p0 + k] - pv_rd[p0 + k - 1]), (k == TOTAL - 1) ? 0 : 1);
      end
    end
    chk({tag, "_done_latency"}, 32'(done_cyc - pv_cyc[p0 + TOTAL - 1]), 1);
    chk({tag, "_busy_at_done"}, 32'(done_busy_viol - dbv0), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_push_rule"}, 32'(rule_viol - rv0), 0);
    chk({tag, "_data_hold"}, 32'(hold_viol - hv0), 0);
`ifdef CONV11_FEEDER_STALL_CNT_EN
    chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(sum));
`endif
  endtask

  initial begin
    logic [AW-1:0] b;
    int p0, n;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    set_dly(0);
    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
`ifdef CONV11_FEEDER_STALL_CNT_EN
    chk("reset_stall_cycles", 32'(stall_cycles), 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_seq(12'h010);
    run_pass(12'h010, 0, "seq");
    dly[0] = 10;
    run_pass(12'h010, 0, "stall10");
    set_dly(0);
    run_pass(12'h010, 1, "mid_start");
    fill_rand(12'hFFE);
    set_dly(4);
    run_pass(12'hFFE, 2, "wrap");

    // abandon a pass with reset after the 5th push
    fill_seq(12'h010);
    set_dly(0);
    p0 = npush;
    @(negedge clk); #1;
    base_addr = 12'h010;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (npush < p0 + 5 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("midrst_reach5", 32'(npush - p0), 5);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    run_pass(12'h010, 0, "after_rst");

    for (int r = 0; r < 3; r++) begin
      b = AW'($urandom);
      fill_rand(b);
      set_dly(4);
      run_pass(b, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/conv11_input_feeder.md
Name: conv11_input_feeder

Overview:
Producer side of the conv1x1 input-buffer interface. On `start`, it walks a feature map stored in a synchronous-read RAM in pixel-major order, with channel as the innermost index. It pushes one word per transfer into the single-entry conv1x1 input buffer, using that buffer's `inputbuf_load` flag as backpressure. It sits between the feature-map RAM and the conv1x1 input buffer, and is controlled by the layer sequencer.

Parameters:
DATA_WIDTH, 8, word width of feature-map data
ADDR_WIDTH, 12, RAM address width
IMG_W, 4, feature-map width in pixels
IMG_H, 4, feature-map height in pixels
IN_CH, 3, input channels per pixel; total words TOTAL = IMG_W*IMG_H*IN_CH, which must be at most 2^ADDR_WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin one pass; ignored unless idle
base_addr  input  ADDR_WIDTH  RAM address of word 0; sampled on accepted start
mem_rd_en  output  1  RAM read strobe
mem_addr  output  ADDR_WIDTH  RAM read address
mem_rd_data  input  DATA_WIDTH  RAM read data, valid the cycle after mem_rd_en
inputbuf_load  input  1  buffer-occupied flag from conv1x1 input buffer
input_valid  output  1  push strobe to buffer
data_in  output  DATA_WIDTH  pushed word
last_ch  output  1  high with input_valid when the word is channel IN_CH-1
last_word  output  1  high with input_valid on the final word of the pass
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the final push

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; counters 0; stage register empty.
- Buffer semantics relied on:
  - input_valid at cycle t sets inputbuf_load at t+1.
  - A consumer read clears it one cycle after the read.
  - A push in the same cycle as a read keeps it set.
- Push rule: input_valid may assert in cycle t only if inputbuf_load==0 at t AND input_valid==0 at t-1. Back-to-back pushes are therefore impossible, and a word is never overwritten before it is read.
- FSM states:
  - IDLE: on start, go to FETCH. Latch base_addr; word counter widx=0, channel counter ch=0; busy=1.
  - FETCH: mem_rd_en=1, mem_addr=base_addr+widx; go to CAPTURE.
  - CAPTURE: register mem_rd_data into stage register; go to PUSH.
  - PUSH: wait until push rule holds, then assert input_valid for exactly one cycle with data_in=stage. In that cycle:
    - last_ch=(ch==IN_CH-1); last_word=(widx==TOTAL-1).
    - If last word, go to DONE.
    - Otherwise increment widx; ch wraps IN_CH-1 to 0. In the same cycle issue FETCH for the next address (mem_rd_en=1) and go to CAPTURE, so there is a 1-word prefetch.
  - DONE: done=1 for one cycle, busy=0, back to IDLE.
- Throughput with an always-ready consumer: one word per 2 cycles in steady state. Latency from start to first input_valid is 3 cycles if inputbuf_load==0.
- data_in holds its last value when input_valid=0. last_ch and last_word are 0 when input_valid=0.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silently permitted.
- start while busy: ignored, with no effect on the pass in progress.
- start in the same cycle as done: ignored, so a new start is needed in IDLE.
- inputbuf_load held high indefinitely: FSM stalls in PUSH, stage data is held, and there are no extra RAM reads.
- rst_n asserted mid-pass: everything returns to reset values immediately and the pass is abandoned.

Optional Feature:
Macro CONV11_FEEDER_STALL_CNT_EN.
- Defined: adds output port `stall_cycles` (16 bits), which counts cycles spent in PUSH with the push rule false during the current pass.
  - Cleared on accepted start; saturates at 16'hFFFF.
  - Holds its value after done until the next start. Reset value 0.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- IMG_W=2, IMG_H=2, IN_CH=3, base_addr=0x010, RAM[0x010+i]=i+1, consumer reads one cycle after each load rises -> 12 pushes of data 1..12.
  - last_ch on words 3, 6, 9, 12; last_word only on word 12.
  - done pulse one cycle after the 12th push; busy low after it.
- Consumer holds off reads for 10 cycles after the 1st push -> no second input_valid while inputbuf_load=1; data_in stays 1; mem_rd_en pulses exactly once more during the stall.
- start pulsed at cycle 5 of an active pass -> ignored; exactly 12 pushes and one done.
- rst_n driven low after the 5th push -> all outputs 0 asynchronously. A new start with base_addr=0x010 then restarts at data 1.
- base_addr=(2^ADDR_WIDTH)-2 -> mem_addr sequence FFE, FFF, 000, 001, ...; data order follows.
- With CONV11_FEEDER_STALL_CNT_EN and a 10-cycle consumer stall on one word -> stall_cycles=10 at done. Re-running with no stalls -> stall_cycles=0.
